// File: rtl/alu_reservation_station.sv
// alu_reservation_station: collapsing-queue reservation station for the ALU.
// Slot 0 holds the oldest entry; slots 0..count-1 are valid. Sources wake from
// a single CDB broadcast; the oldest entry with both sources ready is offered
// to the ALU. An issued slot is removed and every younger slot shifts down.
// Optional feature macro: RS_WAKEUP_ISSUE_EN. When it is defined, a source that
// matches the current broadcast counts as ready in the same cycle and its
// operand is taken from cdb_value.
module alu_reservation_station #(
  parameter int DEPTH = 8,
  parameter int OP_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            disp_valid,
  output logic            disp_ready,
  input  logic [31:0]     disp_pc,
  input  logic [OP_W-1:0] disp_op,
  input  logic            disp_src1_rdy,
  input  logic            disp_src2_rdy,
  input  logic [31:0]     disp_src1_val,
  input  logic [31:0]     disp_src2_val,
  input  logic [31:0]     disp_src1_tag,
  input  logic [31:0]     disp_src2_tag,
  input  logic            cdb_valid,
  input  logic [31:0]     cdb_tag,
  input  logic [31:0]     cdb_value,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [31:0]     issue_pc,
  output logic [OP_W-1:0] issue_op,
  output logic [31:0]     issue_a,
  output logic [31:0]     issue_b
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // registered entry state
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] rdy1_q, rdy2_q;
  logic [31:0]      pc_q   [DEPTH];
  logic [OP_W-1:0]  op_q   [DEPTH];
  logic [31:0]      tag1_q [DEPTH];
  logic [31:0]      tag2_q [DEPTH];
  logic [31:0]      val1_q [DEPTH];
  logic [31:0]      val2_q [DEPTH];

  // entries with this cycle's wakeup applied; slot DEPTH is a blank filler
  // that the top slot reads when the queue collapses
  logic [DEPTH-1:0] hit1, hit2;
  logic [DEPTH:0]   rdy1_w, rdy2_w;
  logic [31:0]      pc_w   [DEPTH+1];
  logic [OP_W-1:0]  op_w   [DEPTH+1];
  logic [31:0]      tag1_w [DEPTH+1];
  logic [31:0]      tag2_w [DEPTH+1];
  logic [31:0]      val1_w [DEPTH+1];
  logic [31:0]      val2_w [DEPTH+1];

  // next state
  logic [CNT_W-1:0] n_count;
  logic [DEPTH-1:0] n_rdy1, n_rdy2;
  logic [31:0]      n_pc   [DEPTH];
  logic [OP_W-1:0]  n_op   [DEPTH];
  logic [31:0]      n_tag1 [DEPTH];
  logic [31:0]      n_tag2 [DEPTH];
  logic [31:0]      n_val1 [DEPTH];
  logic [31:0]      n_val2 [DEPTH];

  logic [DEPTH-1:0] valid_v, ok1, ok2, elig;
  logic             sel_found;
  logic [CNT_W-1:0] sel_idx;
  logic             do_issue, do_disp;
  logic [CNT_W-1:0] wr_slot;
  logic             d_hit1, d_hit2;

  assign disp_ready = (count < CNT_W'(DEPTH));
  assign do_issue   = sel_found && issue_ready;
  assign do_disp    = disp_valid && disp_ready;
  assign wr_slot    = count - CNT_W'(do_issue);
  assign d_hit1     = cdb_valid && !disp_src1_rdy && (disp_src1_tag == cdb_tag);
  assign d_hit2     = cdb_valid && !disp_src2_rdy && (disp_src2_tag == cdb_tag);

  // CDB tag match per waiting source, and the woken view of every slot
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    rdy1_w = '0;
    rdy2_w = '0;
    for (int i = 0; i <= DEPTH; i++) begin
      pc_w[i]   = '0;
      op_w[i]   = '0;
      tag1_w[i] = '0;
      tag2_w[i] = '0;
      val1_w[i] = '0;
      val2_w[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i]   = cdb_valid && !rdy1_q[i] && (tag1_q[i] == cdb_tag);
      hit2[i]   = cdb_valid && !rdy2_q[i] && (tag2_q[i] == cdb_tag);
      rdy1_w[i] = rdy1_q[i] | hit1[i];
      rdy2_w[i] = rdy2_q[i] | hit2[i];
      pc_w[i]   = pc_q[i];
      op_w[i]   = op_q[i];
      tag1_w[i] = tag1_q[i];
      tag2_w[i] = tag2_q[i];
      val1_w[i] = hit1[i] ? cdb_value : val1_q[i];
      val2_w[i] = hit2[i] ? cdb_value : val2_q[i];
    end
  end

  // per-slot eligibility: valid and both sources ready
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_v[i] = (CNT_W'(i) < count);
    end
`ifdef RS_WAKEUP_ISSUE_EN
    ok1 = rdy1_q | hit1;
    ok2 = rdy2_q | hit2;
`else
    ok1 = rdy1_q;
    ok2 = rdy2_q;
`endif
    elig = valid_v & ok1 & ok2;
  end

  // oldest-ready select: scan downward so the lowest eligible index wins
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel_found = 1'b1;
        sel_idx   = CNT_W'(i);
      end
    end
  end

  // issue outputs, zero whenever nothing is selected
  always_comb begin
    issue_valid = sel_found;
    issue_pc    = '0;
    issue_op    = '0;
    issue_a     = '0;
    issue_b     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_found && (sel_idx == CNT_W'(i))) begin
        issue_pc = pc_q[i];
        issue_op = op_q[i];
`ifdef RS_WAKEUP_ISSUE_EN
        issue_a  = rdy1_q[i] ? val1_q[i] : cdb_value;
        issue_b  = rdy2_q[i] ? val2_q[i] : cdb_value;
`else
        issue_a  = val1_q[i];
        issue_b  = val2_q[i];
`endif
      end
    end
  end

  // collapse above the issued slot, then drop the new entry at the tail
  always_comb begin
    n_count = count + CNT_W'(do_disp) - CNT_W'(do_issue);
    n_rdy1  = '0;
    n_rdy2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (do_issue && (CNT_W'(i) >= sel_idx)) begin
        n_rdy1[i] = rdy1_w[i+1];
        n_rdy2[i] = rdy2_w[i+1];
        n_pc[i]   = pc_w[i+1];
        n_op[i]   = op_w[i+1];
        n_tag1[i] = tag1_w[i+1];
        n_tag2[i] = tag2_w[i+1];
        n_val1[i] = val1_w[i+1];
        n_val2[i] = val2_w[i+1];
      end else begin
        n_rdy1[i] = rdy1_w[i];
        n_rdy2[i] = rdy2_w[i];
        n_pc[i]   = pc_w[i];
        n_op[i]   = op_w[i];
        n_tag1[i] = tag1_w[i];
        n_tag2[i] = tag2_w[i];
        n_val1[i] = val1_w[i];
        n_val2[i] = val2_w[i];
      end
      if (do_disp && (wr_slot == CNT_W'(i))) begin
        n_rdy1[i] = disp_src1_rdy | d_hit1;
        n_rdy2[i] = disp_src2_rdy | d_hit2;
        n_pc[i]   = disp_pc;
        n_op[i]   = disp_op;
        n_tag1[i] = disp_src1_tag;
        n_tag2[i] = disp_src2_tag;
        n_val1[i] = d_hit1 ? cdb_value : disp_src1_val;
        n_val2[i] = d_hit2 ? cdb_value : disp_src2_val;
      end
    end
  end

  // control state: occupancy and ready bits; flush empties the queue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      rdy1_q <= '0;
      rdy2_q <= '0;
    end else if (flush) begin
      count  <= '0;
      rdy1_q <= '0;
      rdy2_q <= '0;
    end else begin
      count  <= n_count;
      rdy1_q <= n_rdy1;
      rdy2_q <= n_rdy2;
    end
  end

  // payload: only meaningful under count/rdy, so it carries no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      pc_q[i]   <= n_pc[i];
      op_q[i]   <= n_op[i];
      tag1_q[i] <= n_tag1[i];
      tag2_q[i] <= n_tag2[i];
      val1_q[i] <= n_val1[i];
      val2_q[i] <= n_val2[i];
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: a vector table for the
// per-cycle behaviour plus hand sequences for full, flush and async reset.
module tb_alu_reservation_station;
  localparam int DEPTH = 8;
  localparam int OP_W  = 4;
  localparam int NV    = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            disp_valid;
  logic            disp_ready;
  logic [31:0]     disp_pc;
  logic [OP_W-1:0] disp_op;
  logic            disp_src1_rdy, disp_src2_rdy;
  logic [31:0]     disp_src1_val, disp_src2_val;
  logic [31:0]     disp_src1_tag, disp_src2_tag;
  logic            cdb_valid;
  logic [31:0]     cdb_tag, cdb_value;
  logic            issue_valid;
  logic            issue_ready;
  logic [31:0]     issue_pc;
  logic [OP_W-1:0] issue_op;
  logic [31:0]     issue_a, issue_b;

  int checks = 0;
  int errors = 0;

  alu_reservation_station #(.DEPTH(DEPTH), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_pc(disp_pc), .disp_op(disp_op),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_pc(issue_pc), .issue_op(issue_op),
    .issue_a(issue_a), .issue_b(issue_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [31:0] pc;
    logic [3:0]  op;
    logic        r1;
    logic [31:0] v1;
    logic [31:0] t1;
    logic        r2;
    logic [31:0] v2;
    logic [31:0] t2;
    logic        cv;
    logic [31:0] ct;
    logic [31:0] cval;
    logic        ir;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [3:0]  e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    int          e_cnt;
  } vec_t;

  vec_t tv [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush = 0; disp_valid = 0; disp_pc = '0; disp_op = '0;
    disp_src1_rdy = 0; disp_src2_rdy = 0;
    disp_src1_val = '0; disp_src2_val = '0;
    disp_src1_tag = '0; disp_src2_tag = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_value = '0; issue_ready = 0;
  endtask

  task automatic drive(input vec_t v);
    flush = 0;
    disp_valid = v.dv; disp_pc = v.pc; disp_op = v.op;
    disp_src1_rdy = v.r1; disp_src1_val = v.v1; disp_src1_tag = v.t1;
    disp_src2_rdy = v.r2; disp_src2_val = v.v2; disp_src2_tag = v.t2;
    cdb_valid = v.cv; cdb_tag = v.ct; cdb_value = v.cval;
    issue_ready = v.ir;
  endtask

  task automatic disp_ready_entry(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
    disp_valid = 1; disp_pc = pc; disp_op = 4'h3;
    disp_src1_rdy = 1; disp_src1_val = a;
    disp_src2_rdy = 1; disp_src2_val = b;
  endtask

  initial begin
    // dv pc op r1 v1 t1 r2 v2 t2 cv ct cval ir | e_iv e_pc e_op e_a e_b e_cnt
    tv[0]  = '{1, 'h10, 1, 1, 3, 0, 1, 4, 0, 0, 0, 0, 1,          0, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,             1, 'h10, 1, 3, 4, 1};
    tv[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,             0, 0, 0, 0, 0, 0};
    tv[3]  = '{1, 'h44, 2, 1, 'h11, 0, 0, 0, 'h40, 1, 'h40, 'h55, 0, 0, 0, 0, 0, 0, 0};
    tv[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 'h44, 2, 'h11, 'h55, 1};
    tv[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,             1, 'h44, 2, 'h11, 'h55, 1};
    tv[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,             0, 0, 0, 0, 0, 0};
    tv[7]  = '{1, 'h20, 3, 0, 0, 'h10, 1, 9, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0};
    tv[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h14, 'h99, 0,       0, 0, 0, 0, 0, 1};
    tv[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 1};
    tv[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h10, 7, 0,          0, 0, 0, 0, 0, 1};
    tv[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,             1, 'h20, 3, 7, 9, 1};
    tv[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,             0, 0, 0, 0, 0, 0};
    tv[13] = '{1, 'h30, 4, 0, 0, 'hA0, 1, 1, 0, 0, 0, 0, 1,       0, 0, 0, 0, 0, 0};
    tv[14] = '{1, 'h34, 5, 0, 0, 'hA0, 1, 2, 0, 0, 0, 0, 1,       0, 0, 0, 0, 0, 1};
    tv[15] = '{1, 'h38, 6, 0, 0, 'hC0, 1, 3, 0, 0, 0, 0, 1,       0, 0, 0, 0, 0, 2};
    tv[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hC0, 'h0C, 0,       0, 0, 0, 0, 0, 3};
    tv[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,             1, 'h38, 6, 'h0C, 3, 3};
    tv[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,             0, 0, 0, 0, 0, 2};
    tv[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hA0, 'h0A, 0,       0, 0, 0, 0, 0, 2};
    tv[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,             1, 'h30, 4, 'h0A, 1, 2};
    tv[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,             1, 'h34, 5, 'h0A, 2, 1};
    tv[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,             0, 0, 0, 0, 0, 0};
    tv[23] = '{1, 'h50, 7, 1, 5, 0, 1, 6, 0, 0, 0, 0, 1,          0, 0, 0, 0, 0, 0};
    tv[24] = '{1, 'h54, 8, 1, 7, 0, 1, 8, 0, 0, 0, 0, 1,          1, 'h50, 7, 5, 6, 1};
    tv[25] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,             1, 'h54, 8, 7, 8, 1};
    tv[26] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,             0, 0, 0, 0, 0, 0};
    tv[27] = '{1, 'h60, 9, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0};
    tv[28] = '{1, 'h64, 'hA, 0, 0, 'hD0, 1, 4, 0, 0, 0, 0, 0,     1, 'h60, 9, 1, 1, 1};
    tv[29] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hD0, 'h0D, 1,       1, 'h60, 9, 1, 1, 2};
    tv[30] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,             1, 'h64, 'hA, 'h0D, 4, 1};
    tv[31] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,             0, 0, 0, 0, 0, 0};
`ifdef RS_WAKEUP_ISSUE_EN
    // with same-cycle wakeup the broadcast cycle already presents the entry
    // that the following cycle shows in the registered-ready build
    begin
      int wk [3] = '{10, 16, 19};
      for (int k = 0; k < 3; k++) begin
        tv[wk[k]].e_iv = 1;
        tv[wk[k]].e_pc = tv[wk[k]+1].e_pc;
        tv[wk[k]].e_op = tv[wk[k]+1].e_op;
        tv[wk[k]].e_a  = tv[wk[k]+1].e_a;
        tv[wk[k]].e_b  = tv[wk[k]+1].e_b;
      end
    end
`endif

    // reset state
    rst = 0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_pc", issue_pc, 0);
    chk("rst_issue_op", 32'(issue_op), 0);
    chk("rst_issue_a", issue_a, 0);
    chk("rst_issue_b", issue_b, 0);
    rst = 1;

    // vector table
    for (int k = 0; k < NV; k++) begin
      drive(tv[k]);
      #1;
      chk($sformatf("v%0d_issue_valid", k), issue_valid, tv[k].e_iv);
      chk($sformatf("v%0d_count", k), 32'(dut.count), 32'(tv[k].e_cnt));
      chk($sformatf("v%0d_disp_ready", k), disp_ready, 1);
      if (tv[k].e_iv) begin
        chk($sformatf("v%0d_issue_pc", k), issue_pc, tv[k].e_pc);
        chk($sformatf("v%0d_issue_op", k), 32'(issue_op), 32'(tv[k].e_op));
        chk($sformatf("v%0d_issue_a", k), issue_a, tv[k].e_a);
        chk($sformatf("v%0d_issue_b", k), issue_b, tv[k].e_b);
      end
      @(posedge clk);
      #1;
    end

    // full: eight ready entries held back, ninth dispatch dropped
    idle();
    for (int k = 0; k < DEPTH; k++) begin
      disp_ready_entry(32'h100 + 32'(4 * k), 32'(k), 32'(k + 100));
      @(posedge clk);
      #1;
    end
    disp_ready_entry(32'h200, 32'h77, 32'h77);
    #1;
    chk("full_disp_ready", disp_ready, 0);
    chk("full_count", 32'(dut.count), 8);
    @(posedge clk);
    #1;
    chk("full_ignored_count", 32'(dut.count), 8);
    disp_ready_entry(32'h300, 32'h66, 32'h66);
    issue_ready = 1;
    #1;
    chk("full_issue_disp_ready", disp_ready, 0);
    chk("full_issue_valid", issue_valid, 1);
    chk("full_issue_pc", issue_pc, 32'h100);
    @(posedge clk);
    #1;
    disp_valid = 0;
    #1;
    chk("full_freed_disp_ready", disp_ready, 1);
    chk("full_freed_count", 32'(dut.count), 7);
    for (int k = 1; k < DEPTH; k++) begin
      chk($sformatf("drain%0d_issue_pc", k), issue_pc, 32'h100 + 32'(4 * k));
      chk($sformatf("drain%0d_issue_a", k), issue_a, 32'(k));
      chk($sformatf("drain%0d_issue_b", k), issue_b, 32'(k + 100));
      @(posedge clk);
      #1;
    end
    chk("drain_count", 32'(dut.count), 0);
    chk("drain_issue_valid", issue_valid, 0);

    // flush with five entries and an issue in flight
    idle();
    for (int k = 0; k < 5; k++) begin
      disp_ready_entry(32'h400 + 32'(4 * k), 32'(k), 32'(k));
      @(posedge clk);
      #1;
    end
    disp_ready_entry(32'h500, 1, 1);
    cdb_valid = 1; cdb_tag = 32'h999; cdb_value = 32'h1;
    issue_ready = 1;
    flush = 1;
    #1;
    chk("flush_cycle_issue_valid", issue_valid, 1);
    @(posedge clk);
    #1;
    idle();
    #1;
    chk("flush_count", 32'(dut.count), 0);
    chk("flush_issue_valid", issue_valid, 0);
    chk("flush_disp_ready", disp_ready, 1);
    @(posedge clk);
    #1;
    chk("flush_after_issue_valid", issue_valid, 0);

    // asynchronous reset in mid-cycle with three entries held
    for (int k = 0; k < 3; k++) begin
      disp_ready_entry(32'h600 + 32'(4 * k), 32'(k), 32'(k));
      @(posedge clk);
      #1;
    end
    idle();
    #1;
    chk("prereset_issue_valid", issue_valid, 1);
    #1;
    rst = 0;
    #1;
    chk("async_issue_valid", issue_valid, 0);
    chk("async_disp_ready", disp_ready, 1);
    chk("async_issue_pc", issue_pc, 0);
    chk("async_issue_a", issue_a, 0);
    chk("async_count", 32'(dut.count), 0);
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    chk("postreset_issue_valid", issue_valid, 0);
    chk("postreset_disp_ready", disp_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
